// File: rtl/mv_cand_fetch.sv
// mv_cand_fetch
//   Motion-vector store (one MV per block, {y,x} addressed) with a
//   neighbour-candidate streamer for the MV predictor.
//
//   Ports
//     clk, reset_n              clock, async active-low reset
//     wr_en/wr_pos/wr_mv        MV write-back from the search engine
//     rd_addr -> rd_mv          free-running readout, 1-cycle latency
//     start/mode/curpos         launch a fetch (sampled with start)
//     busy                      fetch occupancy, N+2 cycles
//     cand_valid/idx/mv/avail   one candidate per cycle, in index order
//     done                      flags the last candidate
//
//   Pipeline: ISSUE cycle k computes the neighbour address and reads the
//   RAM (write-first bypass) into stage 1; stage 1 then lands in the
//   output registers, so candidate k appears two edges after its issue.
module mv_cand_fetch #(
  parameter int MV_W     = 14,
  parameter int X_W      = 7,
  parameter int Y_W      = 7,
  parameter int BLK_COLS = 80,
  parameter int BLK_ROWS = 45
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [Y_W+X_W-1:0] wr_pos,
  input  logic [MV_W-1:0]    wr_mv,
  input  logic [Y_W+X_W-1:0] rd_addr,
  output logic [MV_W-1:0]    rd_mv,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [Y_W+X_W-1:0] curpos,
  output logic               busy,
  output logic               cand_valid,
  output logic [2:0]         cand_idx,
  output logic [MV_W-1:0]    cand_mv,
  output logic               cand_avail,
  output logic               done
);

  localparam int A_W   = Y_W + X_W;
  localparam int DEPTH = 1 << A_W;
  localparam logic [X_W:0] COLS = (X_W+1)'(BLK_COLS);
  localparam logic [Y_W:0] ROWS = (Y_W+1)'(BLK_ROWS);

  localparam logic signed [2:0] NEG2 = -3'sd2;
  localparam logic signed [2:0] NEG1 = -3'sd1;
  localparam logic signed [2:0] POS1 = 3'sd1;
  localparam logic signed [2:0] ZERO = 3'sd0;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [2:0]      idx;
    logic            avail;
    logic            last;
    logic [MV_W-1:0] mv;
  } cand_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q;
  logic [X_W-1:0]  cx_q;
  logic [Y_W-1:0]  cy_q;
  logic [2:0]      k_q, k_d, last_q;
  logic            latch, issue;

  logic signed [2:0] dx, dy;
  logic [X_W:0]      sx;
  logic [Y_W:0]      sy;
  logic              avail;
  logic [A_W-1:0]    cand_addr;
  logic [MV_W-1:0]   cand_rd, rd_byp;

  cand_t           s1_q, s1_d;
  logic [1:0]      vld_pipe_q;
  logic            done_q;
  logic [2:0]      cand_idx_q;
  logic [MV_W-1:0] cand_mv_q;
  logic            cand_avail_q;
  logic [MV_W-1:0] rd_mv_q;

  logic [MV_W-1:0] mem [DEPTH];

  // Storage is never cleared; only the write port touches it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_pos] <= wr_mv;
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    latch   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          latch   = 1'b1;
          k_d     = '0;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        k_d   = k_q + 3'd1;
        if (k_q == last_q) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      k_q     <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (latch) begin
        mode_q <= mode;
        cy_q   <= curpos[A_W-1:X_W];
        cx_q   <= curpos[X_W-1:0];
        case (mode)
          2'd1:    last_q <= 3'd3;
          2'd2:    last_q <= 3'd4;
          default: last_q <= 3'd2;
        endcase
      end
    end
  end

  // ------------- neighbour offsets -------------
  // Modes 0, 2 and the reserved mode 3 share L/T/TR in slots 0..2;
  // mode 0/3 never reaches slots 3/4.
  always_comb begin
    dx = ZERO;
    dy = ZERO;
    if (mode_q == 2'd1) begin
      case (k_q)
        3'd0:    begin dx = NEG2; dy = POS1; end
        3'd1:    dy = POS1;
        3'd3:    dx = POS1;
        default: ;
      endcase
    end else begin
      case (k_q)
        3'd0:    dx = NEG1;
        3'd1:    dy = NEG1;
        3'd2:    begin dx = POS1; dy = NEG1; end
        3'd3:    begin dx = NEG1; dy = NEG1; end
        default: ;
      endcase
    end
  end

  // One extra bit so edge offsets never wrap back into the frame. The MSB
  // set means negative (or just past 2^W), both outside the frame.
  always_comb begin
    sx        = {1'b0, cx_q} + {{(X_W-2){dx[2]}}, dx};
    sy        = {1'b0, cy_q} + {{(Y_W-2){dy[2]}}, dy};
    avail     = !sx[X_W] && (sx < COLS) && !sy[Y_W] && (sy < ROWS);
    cand_addr = {sy[Y_W-1:0], sx[X_W-1:0]};
  end

  // Write-first bypass on both read ports.
  assign cand_rd = (wr_en && wr_pos == cand_addr) ? wr_mv : mem[cand_addr];
  assign rd_byp  = (wr_en && wr_pos == rd_addr)   ? wr_mv : mem[rd_addr];

  always_comb begin
    s1_d.idx   = k_q;
    s1_d.avail = avail;
    s1_d.last  = (k_q == last_q);
    s1_d.mv    = avail ? cand_rd : '0;
  end

  // ------------- read / output pipeline -------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q         <= '0;
      vld_pipe_q   <= '0;
      done_q       <= 1'b0;
      cand_idx_q   <= '0;
      cand_mv_q    <= '0;
      cand_avail_q <= 1'b0;
      rd_mv_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], issue};
      done_q     <= vld_pipe_q[0] & s1_q.last;
      rd_mv_q    <= rd_byp;
      if (issue) s1_q <= s1_d;
      // Output fields hold between candidates.
      if (vld_pipe_q[0]) begin
        cand_idx_q   <= s1_q.idx;
        cand_mv_q    <= s1_q.mv;
        cand_avail_q <= s1_q.avail;
      end
    end
  end

  // The FSM is back in IDLE during the done cycle (so a start there is
  // taken) but the fetch still counts as busy until that cycle ends.
  assign busy       = (state_q != IDLE) || done_q;
  assign cand_valid = vld_pipe_q[1];
  assign cand_idx   = cand_idx_q;
  assign cand_mv    = cand_mv_q;
  assign cand_avail = cand_avail_q;
  assign done       = done_q;
  assign rd_mv      = rd_mv_q;

endmodule
